// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It decodes
// the R-type, load, store and branch opcodes, drives the datapath enables, and
// runs a req/ready handshake to one shared instruction/data memory. An illegal
// opcode or a memory timeout sends it to an absorbing TRAP state.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   opcode           IR[6:0], valid from DECODE onward
//   mem_ready        memory completes the current request this cycle
//   mem_req/mem_we   memory request (held until accepted) / 1 = write
//   iord             address select: 0 = PC, 1 = ALUOut
//   ir_write         load IR from the memory read data
//   pc_write         PC <= PC+4
//   pc_write_cond    PC <= branch target if the ALU result is zero
//   alu_src_a/b      ALU operand selects
//   alu_op           00 add, 01 sub, 10 funct decode
//   reg_write        register file write enable
//   mem_to_reg       writeback source: 1 = MDR, 0 = ALUOut
//   retire           one-cycle pulse when an instruction completes
//   trap/trap_cause  sticky trap flag / 01 illegal opcode, 10 memory timeout
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             req_c;

  logic is_r, is_ld, is_st, is_br, legal, tmo_hit;

  assign is_r    = (opcode == OP_R);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_br   = (opcode == OP_BR);
  assign legal   = is_r | is_ld | is_st | is_br;
  assign tmo_hit = (cnt_q == TMO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    req_c         = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    trap          = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c     = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_WB;
        end else if (is_ld || is_st) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else begin
          // Opcode changed after DECODE; treat it as illegal.
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_MEM: begin
        req_c  = 1'b1;
        iord   = 1'b1;
        mem_we = is_st;
        if (mem_ready) begin
          if (is_st) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    mem_req = req_c;

    // Reset gates the outputs combinationally so an in-flight request drops
    // the moment rst_n falls, not at the next clock edge.
    if (!rst_n) begin
      {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, alu_src_a,
       alu_src_b, alu_op, reg_write, mem_to_reg, retire, trap} = '0;
    end
  end

  assign trap_cause = cause_q;

  // Wait counter: cleared on every entry to a requesting state, counts
  // stalled request cycles and saturates at its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
      cnt_d = '0;
    end else if (req_c && !mem_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic       alu_src_a, reg_write, mem_to_reg, retire, trap;
  logic [1:0] alu_src_b, alu_op, trap_cause;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] IL = 7'b0010011;

  // Bit order: mem_req mem_we iord ir_write pc_write pc_write_cond alu_src_a
  //            alu_src_b[2] alu_op[2] reg_write mem_to_reg retire trap cause[2]
  localparam logic [16:0] ZERO     = 17'b0_0_0_0_0_0_0_00_00_0_0_0_0_00;
  localparam logic [16:0] F_WAIT   = 17'b1_0_0_0_0_0_0_01_00_0_0_0_0_00;
  localparam logic [16:0] F_RDY    = 17'b1_0_0_1_1_0_0_01_00_0_0_0_0_00;
  localparam logic [16:0] DEC      = 17'b0_0_0_0_0_0_0_00_00_0_0_0_0_00;
  localparam logic [16:0] EX_R     = 17'b0_0_0_0_0_0_1_00_10_0_0_0_0_00;
  localparam logic [16:0] EX_LS    = 17'b0_0_0_0_0_0_1_10_00_0_0_0_0_00;
  localparam logic [16:0] EX_BR    = 17'b0_0_0_0_0_1_1_00_01_0_0_1_0_00;
  localparam logic [16:0] MEM_LD   = 17'b1_0_1_0_0_0_0_00_00_0_0_0_0_00;
  localparam logic [16:0] MEM_STW  = 17'b1_1_1_0_0_0_0_00_00_0_0_0_0_00;
  localparam logic [16:0] MEM_STR  = 17'b1_1_1_0_0_0_0_00_00_0_0_1_0_00;
  localparam logic [16:0] WB_R     = 17'b0_0_0_0_0_0_0_00_00_1_0_1_0_00;
  localparam logic [16:0] WB_LD    = 17'b0_0_0_0_0_0_0_00_00_1_1_1_0_00;
  localparam logic [16:0] TRAP_ILL = 17'b0_0_0_0_0_0_0_00_00_0_0_0_1_01;
  localparam logic [16:0] TRAP_TMO = 17'b0_0_0_0_0_0_0_00_00_0_0_0_1_10;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // One clock cycle: apply inputs, record the expected outputs for it.
  task automatic cyc(input logic [6:0] op, input logic rdy, input logic [16:0] e,
                     input string nm);
    exp_t x;
    opcode    = op;
    mem_ready = rdy;
    x.name = nm;
    x.v    = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Asserts rst_n between edges; outputs must already be zero at the
  // next falling edge, before any clock edge has seen the reset.
  task automatic do_reset(input string nm);
    exp_t x;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    x.name = nm;
    x.v    = ZERO;
    sb.push_back(x);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation.
  initial begin
    exp_t        x;
    logic [16:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, retire,
               trap, trap_cause};
        checks++;
        if (got !== x.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b", x.name, got, x.v);
        end
      end
    end
  end

  initial begin
    exp_t x;
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;
    x.name = "reset_state";
    x.v    = ZERO;
    sb.push_back(x);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type, zero-wait memory: 4 cycles
    cyc(R, 1, F_RDY, "r_fetch");
    cyc(R, 1, DEC,   "r_decode");
    cyc(R, 1, EX_R,  "r_exec");
    cyc(R, 1, WB_R,  "r_wb");

    // lw, 3 fetch wait cycles: 8 cycles
    for (int i = 0; i < 3; i++) cyc(LW, 0, F_WAIT, "lw_fetch_wait");
    cyc(LW, 1, F_RDY,  "lw_fetch");
    cyc(LW, 1, DEC,    "lw_decode");
    cyc(LW, 1, EX_LS,  "lw_exec");
    cyc(LW, 1, MEM_LD, "lw_mem");
    cyc(LW, 1, WB_LD,  "lw_wb");

    // sw, 2 wait cycles in MEM
    cyc(SW, 1, F_RDY, "sw_fetch");
    cyc(SW, 1, DEC,   "sw_decode");
    cyc(SW, 1, EX_LS, "sw_exec");
    for (int i = 0; i < 2; i++) cyc(SW, 0, MEM_STW, "sw_mem_wait");
    cyc(SW, 1, MEM_STR, "sw_mem_accept");

    // beq: 3 cycles
    cyc(BR, 1, F_RDY, "br_fetch");
    cyc(BR, 1, DEC,   "br_decode");
    cyc(BR, 1, EX_BR, "br_exec");

    // ready arriving on the timeout cycle wins
    for (int i = 0; i < 15; i++) cyc(R, 0, F_WAIT, "edge_fetch_wait");
    cyc(R, 1, F_RDY, "edge_fetch_ready_at_limit");
    cyc(R, 1, DEC,   "edge_decode");
    cyc(R, 1, EX_R,  "edge_exec");
    cyc(R, 1, WB_R,  "edge_wb");

    // fetch timeout: 16 request cycles then TRAP cause 10
    for (int i = 0; i < 16; i++) cyc(R, 0, F_WAIT, "tmo_fetch_wait");
    for (int i = 0; i < 3; i++) cyc(R, 1, TRAP_TMO, "tmo_trap");
    do_reset("reset_from_trap");

    // illegal opcode
    cyc(IL, 1, F_RDY, "ill_fetch");
    cyc(IL, 1, DEC,   "ill_decode");
    for (int i = 0; i < 20; i++) cyc(IL, 1, TRAP_ILL, "ill_trap_hold");
    do_reset("reset_from_ill_trap");

    // async reset in the middle of a fetch wait, then fetch restarts
    for (int i = 0; i < 3; i++) cyc(R, 0, F_WAIT, "mid_fetch_wait");
    do_reset("reset_mid_wait");
    cyc(R, 1, F_RDY, "restart_fetch");
    cyc(R, 1, DEC,   "restart_decode");
    cyc(R, 1, EX_R,  "restart_exec");
    cyc(R, 1, WB_R,  "restart_wb");

    stim_done = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stim_done=%0d expected 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
